// File: rtl/sum_every_n.sv
// Multi-channel grouped-sum accumulator.
// Each channel sums samples into groups of a runtime length.
module sum_every_n #(
  parameter int IW     = 8,
  parameter int NMAX   = 8,
  parameter int CH     = 4,
  parameter bit SIGNED = 1'b0,
  localparam int OW    = IW + $clog2(NMAX),
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1,
  localparam int NW    = $clog2(NMAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_dval,
  input  logic [IW-1:0] i,
  input  logic [CW-1:0] i_ch,
  input  logic          i_last,
  input  logic [NW-1:0] cfg_n,
  output logic          o_dval,
  output logic [OW-1:0] o,
  output logic [CW-1:0] o_ch,
  output logic [NW-1:0] o_cnt,
  output logic [CH-1:0] o_busy
);

  localparam logic [NW-1:0] NMAXW = NW'(NMAX);

  logic [NW-1:0] r_cnt [CH];
  logic [OW-1:0] r_acc [CH];
  logic [NW-1:0] r_len [CH];

  logic          r_dval;
  logic [OW-1:0] r_o;
  logic [CW-1:0] r_ch;
  logic [NW-1:0] r_ocnt;

  logic          w_hit;
  logic [CW-1:0] w_c;
  logic          w_first;
  logic [NW-1:0] w_cfg;
  logic [NW-1:0] w_len;
  logic [NW-1:0] w_cnt1;
  logic [OW-1:0] w_ext;
  logic [OW-1:0] w_sum;
  logic          w_close;

  assign w_hit = i_dval && (int'(i_ch) < CH);
  // Dropped samples still index channel 0, but w_hit gates every write.
  assign w_c   = w_hit ? i_ch : '0;

  assign w_first = (r_cnt[w_c] == '0);
  assign w_cfg   = (cfg_n == '0 || cfg_n > NMAXW) ? NMAXW : cfg_n;
  assign w_len   = w_first ? w_cfg : r_len[w_c];
  assign w_cnt1  = r_cnt[w_c] + NW'(1);

  assign w_ext = SIGNED ? {{(OW-IW){i[IW-1]}}, i}
                        : {{(OW-IW){1'b0}}, i};

  assign w_sum   = (w_first ? '0 : r_acc[w_c]) + w_ext;
  assign w_close = (w_cnt1 == w_len) || i_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dval <= 1'b0;
      r_o    <= '0;
      r_ch   <= '0;
      r_ocnt <= '0;
      for (int k = 0; k < CH; k++) begin
        r_cnt[k] <= '0;
        r_acc[k] <= '0;
        r_len[k] <= '0;
      end
    end else begin
      r_dval <= 1'b0;
      if (w_hit) begin
        if (w_first) begin
          r_len[w_c] <= w_cfg;
        end
        if (w_close) begin
          r_dval     <= 1'b1;
          r_o        <= w_sum;
          r_ch       <= w_c;
          r_ocnt     <= w_cnt1;
          r_cnt[w_c] <= '0;
          r_acc[w_c] <= '0;
        end else begin
          r_acc[w_c] <= w_sum;
          r_cnt[w_c] <= w_cnt1;
        end
      end
    end
  end

  always_comb begin
    o_busy = '0;
    for (int k = 0; k < CH; k++) begin
      o_busy[k] = (r_cnt[k] != '0);
    end
  end

  assign o_dval = r_dval;
  assign o      = r_o;
  assign o_ch   = r_ch;
  assign o_cnt  = r_ocnt;

endmodule

// File: tb/tb_sum_every_n.sv
// Directed bench for sum_every_n: unsigned 3-channel table
// plus a signed single-channel instance.
module tb_sum_every_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        i_dval = 1'b0;
  logic [7:0]  i = '0;
  logic [1:0]  i_ch = '0;
  logic        i_last = 1'b0;
  logic [3:0]  cfg_n = '0;
  logic        o_dval;
  logic [10:0] o;
  logic [1:0]  o_ch;
  logic [3:0]  o_cnt;
  logic [2:0]  o_busy;

  logic        s_dval = 1'b0;
  logic [7:0]  s_i = '0;
  logic        s_ch = 1'b0;
  logic        s_last = 1'b0;
  logic [3:0]  s_cfg = '0;
  logic        s_odval;
  logic [10:0] s_o;
  logic        s_och;
  logic [3:0]  s_ocnt;
  logic        s_busy;

  sum_every_n #(.IW(8), .NMAX(8), .CH(3), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .i_dval(i_dval), .i(i), .i_ch(i_ch),
    .i_last(i_last), .cfg_n(cfg_n),
    .o_dval(o_dval), .o(o), .o_ch(o_ch),
    .o_cnt(o_cnt), .o_busy(o_busy)
  );

  sum_every_n #(.IW(8), .NMAX(8), .CH(1), .SIGNED(1'b1)) u_sdut (
    .clk(clk), .rst(rst),
    .i_dval(s_dval), .i(s_i), .i_ch(s_ch),
    .i_last(s_last), .cfg_n(s_cfg),
    .o_dval(s_odval), .o(s_o), .o_ch(s_och),
    .o_cnt(s_ocnt), .o_busy(s_busy)
  );

  typedef struct {
    logic        dv;
    logic [7:0]  d;
    logic [1:0]  ch;
    logic        last;
    logic [3:0]  cfg;
    logic        xdv;
    logic [10:0] xo;
    logic [1:0]  xch;
    logic [3:0]  xcnt;
    logic [2:0]  xbusy;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic dv, input logic [7:0] d,
                     input logic [1:0] ch, input logic last,
                     input logic [3:0] cfg, input logic xdv,
                     input logic [10:0] xo, input logic [1:0] xch,
                     input logic [3:0] xcnt, input logic [2:0] xbusy);
    vec_t v;
    v.dv = dv; v.d = d; v.ch = ch; v.last = last; v.cfg = cfg;
    v.xdv = xdv; v.xo = xo; v.xch = xch; v.xcnt = xcnt;
    v.xbusy = xbusy;
    tv.push_back(v);
  endtask

  task automatic step(input logic dv, input logic [7:0] d,
                      input logic [1:0] ch, input logic last,
                      input logic [3:0] cfg);
    i_dval = dv; i = d; i_ch = ch; i_last = last; cfg_n = cfg;
    @(posedge clk);
    #1;
    i_dval = 1'b0; i_last = 1'b0;
  endtask

  task automatic chk_main(input string nm, input logic xdv,
                          input logic [10:0] xo, input logic [1:0] xch,
                          input logic [3:0] xcnt, input logic [2:0] xb);
    chk({nm, " dval"}, 32'(o_dval), 32'(xdv));
    chk({nm, " o"}, 32'(o), 32'(xo));
    chk({nm, " ch"}, 32'(o_ch), 32'(xch));
    chk({nm, " cnt"}, 32'(o_cnt), 32'(xcnt));
    chk({nm, " busy"}, 32'(o_busy), 32'(xb));
  endtask

  task automatic sstep(input logic [7:0] d, input logic ch,
                       input logic last, input logic [3:0] cfg);
    s_dval = 1'b1; s_i = d; s_ch = ch; s_last = last; s_cfg = cfg;
    @(posedge clk);
    #1;
    s_dval = 1'b0; s_last = 1'b0;
  endtask

  task automatic chk_s(input string nm, input logic xdv,
                       input logic [10:0] xo, input logic [3:0] xcnt,
                       input logic xb);
    chk({nm, " dval"}, 32'(s_odval), 32'(xdv));
    chk({nm, " o"}, 32'(s_o), 32'(xo));
    chk({nm, " cnt"}, 32'(s_ocnt), 32'(xcnt));
    chk({nm, " busy"}, 32'(s_busy), 32'(xb));
  endtask

  initial begin
    // sum-every-3 on ch0: 1..9
    add(1, 1, 0, 0, 3, 0,    0, 0, 0, 3'b001);
    add(1, 2, 0, 0, 3, 0,    0, 0, 0, 3'b001);
    add(1, 3, 0, 0, 3, 1,    6, 0, 3, 3'b000);
    add(1, 4, 0, 0, 3, 0,    6, 0, 3, 3'b001);
    add(1, 5, 0, 0, 3, 0,    6, 0, 3, 3'b001);
    add(1, 6, 0, 0, 3, 1,   15, 0, 3, 3'b000);
    add(1, 7, 0, 0, 3, 0,   15, 0, 3, 3'b001);
    add(1, 8, 0, 0, 3, 0,   15, 0, 3, 3'b001);
    add(1, 9, 0, 0, 3, 1,   24, 0, 3, 3'b000);
    // interleaved, groups of 2
    add(1, 10,  0, 0, 2, 0,  24, 0, 3, 3'b001);
    add(1, 200, 1, 0, 2, 0,  24, 0, 3, 3'b011);
    add(1, 20,  0, 0, 2, 1,  30, 0, 2, 3'b010);
    add(1, 255, 1, 0, 2, 1, 455, 1, 2, 3'b000);
    // cfg_n=0 -> NMAX on ch2
    for (int k = 0; k < 7; k++)
      add(1, 255, 2, 0, 0, 0, 455, 1, 2, 3'b100);
    add(1, 255, 2, 0, 0, 1, 2040, 2, 8, 3'b000);
    // early termination
    add(1, 4, 0, 0, 3, 0, 2040, 2, 8, 3'b001);
    add(1, 5, 0, 1, 3, 1,    9, 0, 2, 3'b000);
    // cfg_n=1 echo
    add(1, 7,   1, 0, 1, 1,   7, 1, 1, 3'b000);
    add(1, 200, 1, 0, 1, 1, 200, 1, 1, 3'b000);
    // cfg_n latching, ignored i_last, dropped channel
    add(1, 1,  0, 0, 3, 0, 200, 1, 1, 3'b001);
    add(1, 2,  0, 0, 2, 0, 200, 1, 1, 3'b001);
    add(1, 3,  0, 0, 2, 1,   6, 0, 3, 3'b000);
    add(1, 4,  0, 0, 2, 0,   6, 0, 3, 3'b001);
    add(0, 50, 0, 1, 2, 0,   6, 0, 3, 3'b001);
    add(1, 99, 3, 1, 2, 0,   6, 0, 3, 3'b001);
    add(1, 5,  0, 0, 2, 1,   9, 0, 2, 3'b000);

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_main("reset", 0, 0, 0, 0, 3'b000);
    chk_s("sreset", 0, 0, 0, 1'b0);
    rst = 1'b1;

    foreach (tv[k]) begin
      step(tv[k].dv, tv[k].d, tv[k].ch, tv[k].last, tv[k].cfg);
      chk_main($sformatf("v%0d", k), tv[k].xdv, tv[k].xo,
               tv[k].xch, tv[k].xcnt, tv[k].xbusy);
    end

    // reset mid-group: 2 of 3 samples, then async pulse
    step(1, 1, 0, 0, 3);
    step(1, 2, 0, 0, 3);
    chk_main("pre-rst", 0, 9, 0, 2, 3'b001);
    #1 rst = 1'b0;
    #1 chk_main("in-rst", 0, 0, 0, 0, 3'b000);
    @(negedge clk);
    chk_main("in-rst2", 0, 0, 0, 0, 3'b000);
    rst = 1'b1;
    step(1, 10, 0, 0, 3);
    chk_main("post-rst1", 0, 0, 0, 0, 3'b001);
    step(1, 20, 0, 0, 3);
    chk_main("post-rst2", 0, 0, 0, 0, 3'b001);
    step(1, 30, 0, 0, 3);
    chk_main("post-rst3", 1, 60, 0, 3, 3'b000);
    step(0, 0, 0, 0, 3);
    chk_main("post-rst4", 0, 60, 0, 3, 3'b000);

    // signed: four -128 -> -512, then 127 + -1 -> 126
    sstep(8'h80, 0, 0, 4);
    chk_s("s1", 0, 0, 0, 1'b1);
    sstep(8'h80, 0, 0, 4);
    sstep(8'h80, 0, 0, 4);
    chk_s("s3", 0, 0, 0, 1'b1);
    sstep(8'h80, 0, 0, 4);
    chk_s("s4", 1, 11'h600, 4, 1'b0);
    sstep(8'd127, 0, 0, 4);
    chk_s("s5", 0, 11'h600, 4, 1'b1);
    sstep(8'hFF, 1, 1, 4);
    chk_s("sdrop", 0, 11'h600, 4, 1'b1);
    sstep(8'hFF, 0, 1, 4);
    chk_s("s6", 1, 11'd126, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
